// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter
//   Shares one single-port SRAM between the VGA framebuffer fetch port and the
//   CPU data port. VGA has priority so scan-out never underruns. A fairness
//   counter gives the CPU one slot after VGA_BURST back-to-back VGA grants that
//   were made while the CPU was waiting. Only one access is ever in flight.
//
//   Access sequence: IDLE (arbitrate/latch) -> ISSUE (sram_en pulse) ->
//   WAIT (SRAM_LAT-1 cycles, extended by sram_busy) -> DONE (ack) -> IDLE.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   vga_req/vga_addr              VGA read request (held until vga_ack)
//   vga_rdata/vga_ack             fetched word, 1-cycle completion pulse
//   cpu_req/we/addr/wdata/sel     CPU request (held until cpu_ack)
//   cpu_rdata/cpu_ack             read data (0 on writes), 1-cycle completion pulse
//   sram_en/we/addr/wdata/sel     SRAM command; address/data held for the access
//   sram_rdata/sram_busy          SRAM read data, SRAM not-ready stall
//   owner                         0 none, 1 VGA, 2 CPU
module sram_frame_arbiter #(
  parameter int unsigned SRAM_LAT  = 2,
  parameter int unsigned VGA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic [31:0] vga_rdata,
  output logic        vga_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sel,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_sel,
  input  logic [31:0] sram_rdata,
  input  logic        sram_busy,
  output logic [1:0]  owner
);

  // At least one WAIT cycle is always spent, even for SRAM_LAT below 2.
  localparam int unsigned WAIT_CYC = (SRAM_LAT > 1) ? SRAM_LAT - 1 : 1;
  localparam int unsigned LW       = $clog2(WAIT_CYC + 1);
  localparam int unsigned FW       = $clog2(VGA_BURST + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(WAIT_CYC - 1);
  localparam logic [FW-1:0] FAIR_MAX = FW'(VGA_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VGA = 2'd1, OWN_CPU = 2'd2} owner_t;

  state_t        state, state_n;
  owner_t        owner_q;
  logic [FW-1:0] fair_cnt;
  logic [LW-1:0] lat_cnt;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    sel_q;
  logic          we_q;

  logic grant_vga, grant_cpu, capture;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    grant_vga = 1'b0;
    grant_cpu = 1'b0;
    capture   = 1'b0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    vga_ack   = 1'b0;
    cpu_ack   = 1'b0;
    vga_rdata = '0;
    cpu_rdata = '0;
    unique case (state)
      S_IDLE: begin
        if (vga_req && !(cpu_req && fair_cnt == FAIR_MAX)) begin
          grant_vga = 1'b1;
          state_n   = S_ISSUE;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_n   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sram_en = 1'b1;
        sram_we = we_q;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == '0 && !sram_busy) begin
          capture = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (owner_q == OWN_VGA) begin
          vga_ack   = 1'b1;
          vga_rdata = rdata_q;
        end else if (owner_q == OWN_CPU) begin
          cpu_ack   = 1'b1;
          cpu_rdata = we_q ? '0 : rdata_q;
        end
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      fair_cnt <= '0;
      lat_cnt  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      if (grant_vga) begin
        addr_q   <= vga_addr;
        wdata_q  <= '0;
        sel_q    <= '1;
        we_q     <= 1'b0;
        owner_q  <= OWN_VGA;
        // Only VGA grants made while the CPU waits count towards its slot.
        if (!cpu_req)                fair_cnt <= '0;
        else if (fair_cnt != FAIR_MAX) fair_cnt <= fair_cnt + 1'b1;
      end else if (grant_cpu) begin
        addr_q   <= cpu_addr;
        wdata_q  <= cpu_wdata;
        sel_q    <= cpu_sel;
        we_q     <= cpu_we;
        owner_q  <= OWN_CPU;
        fair_cnt <= '0;
      end

      if (state == S_ISSUE)                    lat_cnt <= LAT_LOAD;
      else if (state == S_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;

      if (capture)          rdata_q <= sram_rdata;
      if (state == S_DONE)  owner_q <= OWN_NONE;
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_sel   = sel_q;
  assign owner      = owner_q;

endmodule
